spi_flash_xip_reader: RTL

- Serial-flash read engine inside soc_top, directly upstream of the external SPI NOR flash (N25Q-class, SPI mode 0).
- Converts a 32-bit word-read request from the SoC fabric into one complete SPI transaction: opcode, 24-bit address, then 32 data bits.
- Drives spi_clk, spi_cs, spi_mosi and samples spi_miso.
- Returns the assembled word over a valid/ready response channel.

---
 rtl/spi_flash_pkg.sv | 20 ++
 rtl/spi_flash_xip_reader_sck_gen.sv | 31 +++
 rtl/spi_flash_xip_reader.sv | 100 ++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, frame sizes and FSM states shared by the XIP flash reader.
// SPI_FAST_READ_EN selects FAST_READ (0x0B plus dummy clocks) instead of READ (0x03).
package spi_flash_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam int DUMMY_CYCLES = 8;
`ifdef SPI_FAST_READ_EN
  localparam bit FAST_READ = 1'b1;
`else
  localparam bit FAST_READ = 1'b0;
`endif
  localparam logic [7:0] OPCODE = FAST_READ ? OP_FAST_READ : OP_READ;
  localparam int DATA_BITS = 32;
  localparam int PAD_BITS = DATA_BITS + (FAST_READ ? DUMMY_CYCLES : 0);
  localparam int FRAME_LEN = 8 + 24 + PAD_BITS;
  typedef enum logic [1:0] {IDLE, SHIFT, CS_END, RESP} state_e;
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_flash_xip_reader_sck_gen.sv
// spi_sck_gen: divides clk into a mode-0 spi_clk; strobes are high in the cycle just before each spi_clk edge.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  logic [7:0] cnt_q, cnt_d;
  logic sck_q, sck_d, tick;
  always_comb begin
    tick = en_i && cnt_q == 8'(CLK_DIV - 1);
    cnt_d = (en_i && !tick) ? cnt_q + 8'd1 : 8'd0;
    sck_d = en_i && (sck_q ^ tick);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end
  assign sck_o = sck_q;
  assign rise_stb_o = tick && !sck_q;
  assign fall_stb_o = tick && sck_q;
endmodule

// File: rtl/spi_flash_xip_reader.sv
// spi_flash_xip_reader: turns a 32-bit word read into one SPI mode-0 READ transaction on the NOR flash.
// Build with SPI_FAST_READ_EN defined to issue FAST_READ with dummy clocks instead.
module spi_flash_xip_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_NUM = 2,
  parameter int CS_HIGH = 4,
  localparam int SEL_W = CS_NUM > 1 ? $clog2(CS_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [23:0]       req_addr,
  input  logic [SEL_W-1:0]  req_cs_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic              spi_clk,
  output logic [CS_NUM-1:0] spi_cs,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  state_e state_q, state_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [6:0] bit_q, bit_d;
  logic [31:0] rx_q, rx_d, data_q, data_d;
  logic [7:0] guard_q, guard_d;
  logic rise_stb, fall_stb, shifting, cs_ok;
  assign shifting = state_q == SHIFT;
  assign cs_ok = 32'(sel_q) < CS_NUM;
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (shifting),
    .sck_o      (spi_clk),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    sel_d = sel_q;
    bit_d = bit_q;
    rx_d = rx_q;
    data_d = data_q;
    // guard counts cycles with CS deasserted and saturates once the gap is long enough
    guard_d = shifting ? 8'd0 : (guard_q == 8'(CS_HIGH) ? guard_q : guard_q + 8'd1);
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        frame_d = {OPCODE, req_addr, {PAD_BITS{1'b0}}};
        sel_d = req_cs_sel;
        bit_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (rise_stb) rx_d = {rx_q[30:0], spi_miso};
        if (fall_stb) begin
          frame_d = frame_q << 1;
          bit_d = bit_q + 7'd1;
          if (bit_q == 7'(FRAME_LEN - 1)) state_d = CS_END;
        end
      end
      CS_END: begin
        data_d = cs_ok ? byte_swap(rx_q) : '1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      sel_q <= '0;
      bit_q <= '0;
      rx_q <= '0;
      data_q <= '0;
      guard_q <= 8'(CS_HIGH);
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      sel_q <= sel_d;
      bit_q <= bit_d;
      rx_q <= rx_d;
      data_q <= data_d;
      guard_q <= guard_d;
    end
  end
  assign req_ready = state_q == IDLE && guard_q == 8'(CS_HIGH);
  assign rsp_valid = state_q == RESP;
  assign rsp_data = data_q;
  assign busy = state_q != IDLE;
  assign spi_mosi = shifting && frame_q[FRAME_LEN-1];
  assign spi_cs = (shifting && cs_ok) ? ~(CS_NUM'(1) << sel_q) : '1;
endmodule
